// File: rtl/ddn_arbiter.sv
// ddn_arbiter: round-robin packet arbiter with per-packet lock and
// credit-based flow control toward a downstream FIFO.
// Optional lock watchdog: define DDN_ARB_TIMEOUT_EN to force-release an
// owner that stops presenting beats mid-packet for TIMEOUT cycles.
module ddn_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int CREDITS    = 8,
   parameter int TIMEOUT    = 16,
   localparam int IW        = $clog2(N_REQ),
   localparam int CW        = $clog2(CREDITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_last,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_last,
   output logic [IW-1:0]               out_src,
   input  logic                        credit_return,
   output logic [CW-1:0]               credits_avail,
   output logic                        cred_err,
   output logic                        lock_err
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]           credits_q, credits_d;
   logic                    cred_err_q, cred_err_d;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic                    out_last_q;
   logic [IW-1:0]           out_src_q;

   logic [DATA_WIDTH-1:0]   data_arr [N_REQ];
   logic                    pick_valid;
   logic [IW-1:0]           pick_idx;
   logic                    accept;
   logic                    tmo_fire;

   // Unpack payloads and build the one-hot ready vector for the owner.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign req_ready[gi] = (state_q == ST_LOCKED) && (owner_q == IW'(gi))
                                && (credits_q != '0);
      end
   endgenerate

   assign accept = req_valid[owner_q] && req_ready[owner_q];

   // Round-robin pick: first valid index at or after rr_ptr, wrapping.
   // Scanning offsets high-to-low lets the smallest offset win last.
   always_comb begin
      logic [IW-1:0] cand;
      cand       = '0;
      pick_valid = 1'b0;
      pick_idx   = rr_ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = rr_ptr_q + IW'(k);
         if (req_valid[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Lock FSM: arbitrate in IDLE, hold the owner until its last beat.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_LOCKED;
               owner_d = pick_idx;
            end
         end
         ST_LOCKED: begin
            if ((accept && req_last[owner_q]) || tmo_fire) begin
               state_d  = ST_IDLE;
               rr_ptr_d = owner_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Credit counter: beats consume, returns refill; overflow is flagged and dropped.
   always_comb begin
      credits_d  = credits_q;
      cred_err_d = cred_err_q;
      case ({credit_return, accept})
         2'b10: begin
            if (credits_q == CW'(CREDITS)) cred_err_d = 1'b1;
            else                           credits_d  = credits_q + 1'b1;
         end
         2'b01:   credits_d = credits_q - 1'b1;
         default: credits_d = credits_q;
      endcase
   end

   // State, credit and output-beat registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         credits_q   <= CW'(CREDITS);
         cred_err_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         credits_q   <= credits_d;
         cred_err_q  <= cred_err_d;
         out_valid_q <= accept;
         if (accept) begin
            out_data_q <= data_arr[owner_q];
            out_last_q <= req_last[owner_q];
            out_src_q  <= owner_q;
         end
      end
   end

`ifdef DDN_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          lock_err_q;

   // Fires on the cycle that would bring the idle count to TIMEOUT.
   assign tmo_fire = (state_q == ST_LOCKED) && !req_valid[owner_q]
                     && (tmo_cnt_q == TW'(TIMEOUT - 1));

   // Idle counter: only cycles where the owner shows no beat count;
   // credit stalls with valid held high neither count nor clear.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if ((state_q != ST_LOCKED) || accept || tmo_fire) tmo_cnt_d = '0;
      else if (!req_valid[owner_q])                      tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   // Watchdog counter and sticky forced-release flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q  <= '0;
         lock_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         if (tmo_fire) lock_err_q <= 1'b1;
      end
   end

   assign lock_err = lock_err_q;
`else
   assign tmo_fire = 1'b0;
   // Watchdog absent: lock is never forced; constant 0 for every legal TIMEOUT.
   assign lock_err = (TIMEOUT < 0);
`endif

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_last      = out_last_q;
   assign out_src       = out_src_q;
   assign credits_avail = credits_q;
   assign cred_err      = cred_err_q;

endmodule

// File: tb/tb_ddn_arbiter.sv
// tb_ddn_arbiter: scoreboard bench for ddn_arbiter (N_REQ=4, CREDITS=8).
// Per-requester packet queues drive the inputs; expected beats are pushed
// when stimulus is queued and popped by the output monitor.
module tb_ddn_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int CR  = 8;
   localparam int TMO = 16;

   typedef struct {
      logic [1:0]    src;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [1:0]      out_src;
   logic            credit_return = 1'b0;
   logic [3:0]      credits_avail;
   logic            cred_err;
   logic            lock_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   beat_t       exp_q[$];
   logic [32:0] src_q[N][$];
   int          out_cyc_q[$];
   int          auto_cnt = 0;
   int          man_cnt = 0;
   int          ret_done = 0;
   bit          auto_ret = 1'b1;

   ddn_arbiter #(
      .N_REQ(N), .DATA_WIDTH(DW), .CREDITS(CR), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_src(out_src),
      .credit_return(credit_return), .credits_avail(credits_avail),
      .cred_err(cred_err), .lock_err(lock_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Driver: retire handshaken heads, present new heads, emit credit returns.
   always begin
      logic [N-1:0] fire;
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]            = 1'b1;
            req_last[i]             = src_q[i][0][32];
            req_data[i*DW +: DW]    = src_q[i][0][31:0];
         end else begin
            req_valid[i]            = 1'b0;
            req_last[i]             = 1'b0;
            req_data[i*DW +: DW]    = '0;
         end
      end
      if (auto_cnt + man_cnt != ret_done) begin
         credit_return = 1'b1;
         ret_done++;
      end else begin
         credit_return = 1'b0;
      end
   end

   // Monitor: every output beat is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         out_cyc_q.push_back(cyc);
         if (auto_ret) auto_cnt++;
         if (exp_q.size() == 0) begin
            chk("beat_unexpected", 64'(out_src), 64'hF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            $display("beat src=%0d data=%08h last=%0d (exp src=%0d data=%08h last=%0d)",
                     out_src, out_data, out_last, e.src, e.data, e.last);
            chk("beat_src", 64'(out_src), 64'(e.src));
            chk("beat_data", 64'(out_data), 64'(e.data));
            chk("beat_last", 64'(out_last), 64'(e.last));
         end
      end
   end

   task automatic send(input int src, input logic [31:0] data, input logic last, input bit expect_out);
      beat_t e;
      src_q[src].push_back({last, data});
      if (expect_out) begin
         e.src  = 2'(src);
         e.data = data;
         e.last = last;
         exp_q.push_back(e);
      end
   endtask

   task automatic expect_beat(input int src, input logic [31:0] data, input logic last);
      beat_t e;
      e.src  = 2'(src);
      e.data = data;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk(tag, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      chk("rst_credits", 64'(credits_avail), 64'(CR));
      chk("rst_cred_err", 64'(cred_err), 64'd0);
      chk("rst_lock_err", 64'(lock_err), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Two requesters with single-beat packets alternate, one packet per 2 cycles
      out_cyc_q.delete();
      send(0, 32'h0000_0A01, 1'b1, 1'b0);
      send(2, 32'h0000_0C01, 1'b1, 1'b0);
      send(0, 32'h0000_0A02, 1'b1, 1'b0);
      send(2, 32'h0000_0C02, 1'b1, 1'b0);
      expect_beat(0, 32'h0000_0A01, 1'b1);
      expect_beat(2, 32'h0000_0C01, 1'b1);
      expect_beat(0, 32'h0000_0A02, 1'b1);
      expect_beat(2, 32'h0000_0C02, 1'b1);
      drain("rr_drain", 40);
      chk("rr_beats", 64'(out_cyc_q.size()), 64'd4);
      if (out_cyc_q.size() == 4)
         for (int k = 1; k < 4; k++)
            chk("rr_spacing", 64'(out_cyc_q[k] - out_cyc_q[k-1]), 64'd2);

      // Multi-beat packet holds the lock against a competing requester
      send(1, 32'h0000_1001, 1'b0, 1'b1);
      send(1, 32'h0000_1002, 1'b0, 1'b1);
      send(1, 32'h0000_1003, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      send(3, 32'h0000_3001, 1'b1, 1'b1);
      @(negedge clk);
      chk("lock_ready3", 64'(req_ready[3]), 64'd0);
      chk("lock_ready1", 64'(req_ready[1]), 64'd1);
      drain("lock_drain", 40);
      repeat (4) @(negedge clk);

      // Credit exhaustion: 8 of 10 beats go out, then one per returned credit
      auto_ret = 1'b0;
      chk("cred_full", 64'(credits_avail), 64'(CR));
      for (int k = 1; k <= 10; k++)
         send(0, 32'h0000_0B00 + 32'(k), (k == 10), (k <= 8));
      drain("cred_drain8", 60);
      repeat (3) @(negedge clk);
      chk("cred_zero", 64'(credits_avail), 64'd0);
      chk("cred_ready0", 64'(req_ready), 64'd0);
      chk("cred_left", 64'(src_q[0].size()), 64'd2);
      expect_beat(0, 32'h0000_0B09, 1'b0);
      man_cnt++;
      drain("cred_one_more", 20);
      repeat (3) @(negedge clk);
      chk("cred_zero2", 64'(credits_avail), 64'd0);
      chk("cred_left2", 64'(src_q[0].size()), 64'd1);
      expect_beat(0, 32'h0000_0B0A, 1'b1);
      man_cnt++;
      drain("cred_last", 20);
      man_cnt += 8;
      repeat (12) @(negedge clk);
      chk("cred_refill", 64'(credits_avail), 64'(CR));
      chk("cred_err_clean", 64'(cred_err), 64'd0);

      // Credit overflow while full is dropped and flagged sticky
      man_cnt++;
      repeat (3) @(negedge clk);
      chk("ovf_credits", 64'(credits_avail), 64'(CR));
      chk("ovf_err", 64'(cred_err), 64'd1);
      repeat (5) @(negedge clk);
      chk("ovf_err_sticky", 64'(cred_err), 64'd1);
      auto_ret = 1'b1;

`ifdef DDN_ARB_TIMEOUT_EN
      // Owner abandons its packet: forced release after TIMEOUT idle cycles
      out_cyc_q.delete();
      send(2, 32'h0000_0D01, 1'b0, 1'b1);
      send(3, 32'h0000_0E01, 1'b1, 1'b1);
      drain("tmo_drain", 100);
      chk("tmo_beats", 64'(out_cyc_q.size()), 64'd2);
      if (out_cyc_q.size() == 2)
         chk("tmo_gap", 64'(out_cyc_q[1] - out_cyc_q[0]), 64'(TMO + 2));
      chk("tmo_lock_err", 64'(lock_err), 64'd1);
`else
      chk("no_tmo_lock_err", 64'(lock_err), 64'd0);
`endif

      // Reset in the middle of a packet from requester 1
      send(1, 32'h0000_1101, 1'b0, 1'b1);
      send(1, 32'h0000_1102, 1'b0, 1'b0);
      send(1, 32'h0000_1103, 1'b1, 1'b0);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         #2;
         if (exp_q.size() == 0) break;
      end
      chk("mid_first_beat", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_last", 64'(out_last), 64'd0);
      chk("mid_rst_credits", 64'(credits_avail), 64'(CR));
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_cred_err", 64'(cred_err), 64'd0);
      src_q[1].delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send(3, 32'h0000_F003, 1'b1, 1'b0);
      send(0, 32'h0000_F000, 1'b1, 1'b0);
      expect_beat(0, 32'h0000_F000, 1'b1);
      expect_beat(3, 32'h0000_F003, 1'b1);
      drain("post_rst_drain", 40);
      chk("post_rst_lock_err", 64'(lock_err), 64'd0);
      chk("post_rst_credits", 64'(credits_avail), 64'(CR));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/ddn_arbiter.md
DDN_ARBITER -- requirements
Module: ddn_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesting input ports (power of two, 2..16).
REQ-002 Parameter DATA_WIDTH, default 32, beat payload width.
REQ-003 Parameter CREDITS, default 8, downstream FIFO slots (1..255).
REQ-004 Parameter TIMEOUT, default 16, idle-lock cycles before forced release (used only with DDN_ARB_TIMEOUT_EN).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  N_REQ  per-requester beat valid.
REQ-008 req_last  input  N_REQ  per-requester last beat of packet.
REQ-009 req_data  input  N_REQ*DATA_WIDTH  packed payloads, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  N_REQ  per-requester accept, combinational from registered state only.
REQ-011 out_valid  output  1  registered beat valid to downstream; downstream accepts unconditionally (credit flow control).
REQ-012 out_data  output  DATA_WIDTH  registered payload.
REQ-013 out_last  output  1  registered last flag.
REQ-014 out_src  output  log2(N_REQ)  registered source index of the beat.
REQ-015 credit_return  input  1  one-cycle pulse per downstream slot freed.
REQ-016 credits_avail  output  log2(CREDITS+1)  current credit count.
REQ-017 cred_err  output  1  sticky credit-overflow flag.
REQ-018 lock_err  output  1  sticky forced-release flag (constant 0 without DDN_ARB_TIMEOUT_EN).

Function
REQ-019 FSM states IDLE and LOCKED; owner register holds the granted index.
REQ-020 IDLE: if any req_valid, select first asserted index at or after rr_ptr (wrapping), latch owner, go LOCKED next cycle; else stay IDLE.
REQ-021 req_ready[i] = (state==LOCKED) && (owner==i) && (credits_avail>0); all other bits 0.
REQ-022 Beat accepted when req_valid[owner] && req_ready[owner]; next cycle out_valid=1 with out_data, out_last, out_src=owner; otherwise out_valid=0 next cycle (latency exactly 1).
REQ-023 Accepted beat with req_last: go IDLE, rr_ptr <= owner+1 mod N_REQ; otherwise stay LOCKED.
REQ-024 Lock held for whole packet; other requesters never granted mid-packet, regardless of their req_valid.
REQ-025 Credits: accepted beat decrements, credit_return increments; both same cycle leaves count unchanged.
REQ-026 credit_return with count==CREDITS and no accepted beat: ignored, cred_err set to 1 until reset.
REQ-027 Credits 0 in LOCKED: req_ready 0, lock kept, no beat issued; resumes the cycle after a credit_return raises count.
REQ-028 Minimum one-beat packet occupancy: 2 cycles (arbitration cycle plus beat cycle).

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, owner=0, rr_ptr=0, credits_avail=CREDITS, out_valid=0, out_data=0, out_last=0, out_src=0, cred_err=0, lock_err=0, timeout counter 0.
REQ-030 Reset mid-packet discards the partial packet; no beat issued until a fresh arbitration after rst_n rises.

Configuration
REQ-031 Macro DDN_ARB_TIMEOUT_EN defined: in LOCKED, counter increments each cycle req_valid[owner] is 0 (counting stalls with valid 1 and credits 0 excluded), clears on accepted beat; reaching TIMEOUT forces IDLE, rr_ptr <= owner+1, lock_err=1 (sticky).
REQ-032 DDN_ARB_TIMEOUT_EN undefined: no counter, lock held indefinitely, lock_err tied 0.

Verification
REQ-033 Reset, then req_valid=4'b0101 single-beat packets repeated -> grants alternate 0,2,0,2; out_src matches; each packet out 2 cycles after arbitration start.
REQ-034 Requester 1 sends 3-beat packet while req_valid[3]=1 -> out_src=1 for 3 consecutive beats, out_last on third, then requester 3 granted.
REQ-035 CREDITS=2, no credit_return, requester 0 sends 4 beats -> 2 beats out, req_ready 0, credits_avail=0; one credit_return pulse -> exactly one more beat.
REQ-036 credit_return pulse with credits_avail=8 (CREDITS=8), idle -> credits_avail stays 8, cred_err=1 and remains 1.
REQ-037 With DDN_ARB_TIMEOUT_EN, TIMEOUT=16: requester 2 sends non-last beat then drops valid -> forced IDLE after 16 cycles, lock_err=1, requester 3 granted next.
REQ-038 rst_n asserted mid-packet of requester 1 -> outputs reset immediately, credits_avail=CREDITS, next grant after release starts at index 0.
